// File: rtl/cv32e40p_obi_mem_arbiter.sv
// Shares one single-port RAM between the instruction and data OBI ports.
// Data has priority; a starvation counter forces an instr win after MAX_WAIT losses.
module cv32e40p_obi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned StarveW = $clog2(MAX_WAIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_WAIT);

  localparam logic [1:0] OwnerNone  = 2'd0;
  localparam logic [1:0] OwnerInstr = 2'd1;
  localparam logic [1:0] OwnerData  = 2'd2;

  logic [1:0]         owner_q, owner_d;
  logic [StarveW-1:0] starve_q, starve_d;

  // Upper data address bits are intentionally dropped by the RAM mapping.
  logic [31:0] unused_data_addr;
  assign unused_data_addr = data_addr_i;

  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (data_req_i && (!instr_req_i || (starve_q != StarveMax))) begin
        data_gnt_o = 1'b1;
      end else if (instr_req_i) begin
        instr_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o   = instr_gnt_o | data_gnt_o;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    if (data_gnt_o) begin
      mem_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else if (instr_gnt_o) begin
      mem_addr_o  = instr_addr_i;
      mem_be_o    = 4'hF;
    end
  end

  always_comb begin
    owner_d = OwnerNone;
    if (instr_gnt_o) begin
      owner_d = OwnerInstr;
    end else if (data_gnt_o) begin
      owner_d = OwnerData;
    end
  end

  always_comb begin
    starve_d = '0;
    if (instr_req_i && !instr_gnt_o) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= OwnerNone;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Gated by reset so a response pending at reset entry is dropped immediately.
  assign instr_rvalid_o = !rst_i && (owner_q == OwnerInstr);
  assign data_rvalid_o  = !rst_i && (owner_q == OwnerData);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_cv32e40p_obi_mem_arbiter.sv
// Directed bench for cv32e40p_obi_mem_arbiter with a behavioural 1-cycle RAM and a
// response scoreboard checked against a bench-owned reference memory.
module tb_cv32e40p_obi_mem_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_gnt, instr_rvalid;
  logic [DW-1:0] instr_rdata;
  logic          data_req;
  logic [31:0]   data_addr;
  logic          data_we;
  logic [3:0]    data_be;
  logic [DW-1:0] data_wdata;
  logic          data_gnt, data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          ram_init;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;  // 1 = data, 0 = instr
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram     [0:2047];
  logic [31:0] ref_mem [0:2047];

  always #5 clk = ~clk;

  cv32e40p_obi_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_req_i   (instr_req),
    .instr_addr_i  (instr_addr),
    .instr_gnt_o   (instr_gnt),
    .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o (instr_rdata),
    .data_req_i    (data_req),
    .data_addr_i   (data_addr),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_wdata_i  (data_wdata),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .mem_be_o      (mem_be),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [10:0] idx);
    return (idx >= 11'h60 && idx < 11'h68) ? (32'hA5A50000 | {21'h0, idx}) : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 2048; k++) ram[k] <= init_word(k[10:0]);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      mem_rdata <= ram[mem_addr[12:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick_rst();
    @(negedge clk);
    chk("rst_gnt", {30'h0, instr_gnt, data_gnt}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    chk("rst_rdata", instr_rdata | data_rdata, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic ei, input logic ed);
    exp_t        e;
    logic [10:0] idx;
    logic [31:0] merged;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rvalid_route", {30'h0, instr_rvalid, data_rvalid}, e.port ? 32'h1 : 32'h2);
      if (e.chk) chk("rdata", e.port ? data_rdata : instr_rdata, e.data);
      chk("other_rdata_zero", e.port ? instr_rdata : data_rdata, 32'h0);
    end else begin
      chk("rvalid_idle", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
      chk("rdata_idle", instr_rdata | data_rdata, 32'h0);
    end
    chk("gnt", {30'h0, instr_gnt, data_gnt}, {30'h0, ei, ed});
    chk("mem_req", {31'h0, mem_req}, {31'h0, ei | ed});
    if (ed) begin
      idx = data_addr[12:2];
      chk("d_addr", {14'h0, mem_addr}, {14'h0, data_addr[AW-1:0]});
      chk("d_we", {31'h0, mem_we}, {31'h0, data_we});
      chk("d_be", {28'h0, mem_be}, {28'h0, data_be});
      chk("d_wdata", mem_wdata, data_wdata);
      e = '{port: 1'b1, chk: !data_we, data: ref_mem[idx]};
      sb.push_back(e);
      if (data_we) begin
        merged = ref_mem[idx];
        for (int b = 0; b < 4; b++) begin
          if (data_be[b]) merged[8*b +: 8] = data_wdata[8*b +: 8];
        end
        ref_mem[idx] = merged;
      end
    end else if (ei) begin
      idx = instr_addr[12:2];
      chk("i_addr", {14'h0, mem_addr}, {14'h0, instr_addr});
      chk("i_we_be", {27'h0, mem_we, mem_be}, 32'hF);
      chk("i_wdata", mem_wdata, 32'h0);
      e = '{port: 1'b0, chk: 1'b1, data: ref_mem[idx]};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) ref_mem[k] = init_word(k[10:0]);
    rst        = 1'b1;
    ram_init   = 1'b1;
    instr_req  = 1'b1;
    instr_addr = 18'h180;
    data_req   = 1'b1;
    data_addr  = 32'h1000;
    data_we    = 1'b0;
    data_be    = 4'hF;
    data_wdata = '0;

    // Reset with both requests held, then release
    tick_rst();
    ram_init = 1'b0;
    tick_rst();
    rst = 1'b0;
    tick(1'b0, 1'b1);
    instr_req = 1'b0;
    data_req  = 1'b0;
    tick(1'b0, 1'b0);

    // Back-to-back instr reads
    instr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_addr = 18'h180 + 18'(4 * i);
      tick(1'b1, 1'b0);
    end
    instr_req = 1'b0;
    tick(1'b0, 1'b0);

    // Partial write then read back
    data_req   = 1'b1;
    data_addr  = 32'h1000;
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_wdata = 32'hDEADBEEF;
    tick(1'b0, 1'b1);
    data_we    = 1'b0;
    data_be    = 4'hF;
    data_wdata = '0;
    tick(1'b0, 1'b1);
    chk("wr_ref_model", ref_mem[11'h400], 32'h0000BEEF);
    data_req = 1'b0;
    tick(1'b0, 1'b0);

    // Continuous contention: D,D,D,D,I
    instr_req  = 1'b1;
    instr_addr = 18'h184;
    data_req   = 1'b1;
    data_addr  = 32'h188;
    for (int i = 0; i < 10; i++) tick(i % 5 == 4, i % 5 != 4);

    // Instr dropping its request clears the starvation count
    instr_req = 1'b0;
    data_req  = 1'b0;
    tick(1'b0, 1'b0);
    instr_req = 1'b1;
    data_req  = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    instr_req = 1'b0;
    tick(1'b0, 1'b1);
    instr_req = 1'b1;
    for (int i = 0; i < 5; i++) tick(i == 4, i != 4);
    instr_req = 1'b0;
    data_req  = 1'b0;
    tick(1'b0, 1'b0);

    // Reset with an instr response pending
    instr_req  = 1'b1;
    instr_addr = 18'h180;
    tick(1'b1, 1'b0);
    instr_req = 1'b0;
    rst       = 1'b1;
    tick_rst();
    rst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Upper data address bits dropped
    data_req  = 1'b1;
    data_addr = 32'hFFFC_0010;
    #3;
    chk("addr_trunc", {14'h0, mem_addr}, 32'h10);
    tick(1'b0, 1'b1);
    data_req = 1'b0;
    tick(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
